// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM states and default operand/digit widths
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;
endpackage

// File: rtl/FAC.sv
// FAC: 1-bit full adder cell
module FAC (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: DIGIT-bit ripple adder built from FAC cells, exposing the carry into the MSB
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cm
);
  logic [DIGIT:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    FAC u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  assign co = c[DIGIT];
  assign cm = c[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/subtract, one DIGIT-wide slice per cycle, LSB digit first
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             done
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  state_t           state, nxt;
  logic [WIDTH-1:0] ra, rb;
  logic             carry, ov, last, dco, dcm;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] ds;
  digit_adder #(.DIGIT(DIGIT)) u_dig (
    .a(ra[DIGIT-1:0]), .b(rb[DIGIT-1:0]), .ci(carry), .s(ds), .co(dco), .cm(dcm)
  );
  assign last = (state == RUN) && (cnt == CW'(N - 1));
  always_comb begin
    nxt = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      sum   <= '0;
      carry <= 1'b0;
      ov    <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        ra    <= a;
        rb    <= sub ? ~b : b;
        carry <= sub | cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        ra                        <= ra >> DIGIT;
        rb                        <= rb >> DIGIT;
        sum[int'(cnt)*DIGIT +: DIGIT] <= ds;
        carry                     <= dco;
        cnt                       <= cnt + CW'(1);
        if (last) ov <= dcm ^ dco;
      end
    end
  end
  assign ready    = state == IDLE;
  assign done     = state == DONE;
  assign cout     = carry;
  assign overflow = ov;
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter DIGIT, default 4, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, with 1 <= DIGIT <= WIDTH.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request to begin an operation; accepted only when ready=1.
REQ-006 a  input  WIDTH  first operand, sampled on the accept cycle.
REQ-007 b  input  WIDTH  second operand, sampled on the accept cycle.
REQ-008 cin  input  1  carry-in, sampled on the accept cycle; ignored when sub=1.
REQ-009 sub  input  1  mode, sampled on the accept cycle: 0 = a+b+cin, 1 = a-b.
REQ-010 ready  output  1  high only in IDLE.
REQ-011 sum  output  WIDTH  result register.
REQ-012 cout  output  1  final carry out; in subtract mode, 1 means no borrow.
REQ-013 overflow  output  1  two's-complement signed overflow of the result.
REQ-014 done  output  1  one-cycle pulse marking the cycle in which sum, cout and overflow first become valid.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE; N = WIDTH/DIGIT.
REQ-016 IDLE -> RUN when start=1; the cycle in which this edge occurs is cycle 0. That edge latches a, the effective b and the carry: ~b and carry 1 when sub=1, otherwise b and cin.
REQ-017 RUN SHALL last exactly N cycles; in RUN cycle k (k = 0..N-1) digit k (bits k*DIGIT+DIGIT-1 .. k*DIGIT, LSB digit first) is added with the registered carry.
REQ-018 Each digit's sum bits SHALL be written into sum, and the digit carry-out into the carry register, on the edge ending that RUN cycle.
REQ-019 RUN -> DONE after digit N-1; in DONE, done=1 and sum, cout and overflow are valid; the next cycle is IDLE.
REQ-020 Latency from the accept edge to done=1 SHALL be N+1 cycles; with the defaults, done is high in cycle 5.
REQ-021 overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-022 sum, cout and overflow SHALL hold their values from DONE until the next accepted start.
REQ-023 start while in RUN or DONE SHALL be ignored: no latch, no queueing and no effect on the current result.
REQ-024 start held high SHALL be accepted again on the first IDLE cycle, so back-to-back operations run every N+2 cycles.
REQ-025 Operand inputs changing after the accept cycle SHALL NOT affect the result.
REQ-026 With DIGIT=WIDTH, N=1 and done SHALL occur in cycle 2.

Reset
REQ-027 While rst=1 on a clock edge, the FSM SHALL go to IDLE; sum, cout, overflow, done and internal carry SHALL clear to 0; ready SHALL be 1 in the cycle after reset.
REQ-028 rst SHALL take priority over start, including when both are asserted together.
REQ-029 rst asserted during RUN or DONE SHALL abort the operation; no done pulse for it.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH/DIGIT constants.
REQ-031 The per-cycle digit adder SHALL be a sub-module, digit_adder (DIGIT bits, carry-in, carry-out, carry into MSB), built as a chain of the team's existing 1-bit full adder cell FAC.
REQ-032 Operands SHALL be held in right-shifting registers, with a digit counter of $clog2(N+1) bits.

Verification (WIDTH=16, DIGIT=4 unless noted)
REQ-033 a=0x1234, b=0x0FFF, cin=0, sub=0 -> sum=0x2233, cout=0, overflow=0, done in cycle 5.
REQ-034 a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, cout=1, overflow=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1.
REQ-035 sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, overflow=0; a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, overflow=1.
REQ-036 start pulsed again in RUN cycle 2 with new operands -> ignored, first result unchanged, one done pulse only.
REQ-037 rst in RUN cycle 2 -> IDLE next cycle, all outputs 0, no done; a following operation is correct.
REQ-038 DIGIT=16: a=0xABCD, b=0x1111, cin=1 -> sum=0xBCDF, done in cycle 2; start held high -> done every 3 cycles.
